// File: rtl/mcp_pkg.sv
// mcp_pkg: shared definitions for the multicycle accumulator array.
//   - mcp_state_t : FSM state encoding (IDLE/BUSY/HOLD)
//   - cnt_width() : width of the multicycle down-counter for a given factor
package mcp_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      HOLD = 2'd2
   } mcp_state_t;

   // Counter must hold CYCLES-1; never narrower than one bit so CYCLES=1
   // still yields a legal (always-zero) counter.
   function automatic int cnt_width(input int cycles);
      int w;
      w = $clog2(cycles);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/mcp_lane.sv
// mcp_lane: one WIDTH-bit accumulator lane.
//   clk1        : clock, all state on posedge
//   rst         : synchronous active-high reset
//   launch_en   : load launch_data into the launch register
//   capture_en  : capture launch + feedback into sum/carry/feedback regs
//   fb_clr      : when high the adder uses 0 instead of the feedback value
//   launch_data : lane operand
//   sum_data    : captured sum (mod 2^WIDTH)
//   sum_carry   : carry-out of the captured add
// The adder between launch_reg/fb_reg and the capture registers is the
// multicycle path; its inputs only change on launch/capture edges.
module mcp_lane #(
   parameter int WIDTH = 8
) (
   input  logic             clk1,
   input  logic             rst,
   input  logic             launch_en,
   input  logic             capture_en,
   input  logic             fb_clr,
   input  logic [WIDTH-1:0] launch_data,
   output logic [WIDTH-1:0] sum_data,
   output logic             sum_carry
);

   logic [WIDTH-1:0] launch_reg;
   logic [WIDTH-1:0] fb_reg;
   logic [WIDTH-1:0] sum_reg;
   logic             carry_reg;
   logic [WIDTH-1:0] addend;
   logic [WIDTH:0]   add_full;

   assign addend   = fb_clr ? '0 : fb_reg;
   assign add_full = {1'b0, launch_reg} + {1'b0, addend};

   always_ff @(posedge clk1) begin
      if (rst) begin
         launch_reg <= '0;
         fb_reg     <= '0;
         sum_reg    <= '0;
         carry_reg  <= 1'b0;
      end else begin
         if (launch_en) begin
            launch_reg <= launch_data;
         end
         if (capture_en) begin
            sum_reg   <= add_full[WIDTH-1:0];
            carry_reg <= add_full[WIDTH];
            fb_reg    <= add_full[WIDTH-1:0];
         end
      end
   end

   assign sum_data  = sum_reg;
   assign sum_carry = carry_reg;

endmodule

// File: rtl/mcp_accum_array.sv
// mcp_accum_array: CHANNELS independent WIDTH-bit accumulators whose adders
// form a multicycle path of exactly CYCLES clock periods.
//   clk1       : clock, all state on posedge
//   rst        : synchronous active-high reset
//   in_valid   : producer offers an operand vector
//   in_ready   : block accepts an operand (IDLE only)
//   in_data    : operands, lane c at [c*WIDTH +: WIDTH]
//   in_clr     : with the accepted operand, use feedback 0 for that op
//   out_valid  : result available (HOLD)
//   out_ready  : consumer accepts the result
//   out_data   : captured sums, same lane packing
//   out_carry  : per-lane carry-out
//   mc_launch  : registered launch enable (timing -through point)
//   mc_capture : registered capture enable
// Launch edge = accept edge; capture edge is CYCLES edges later.
module mcp_accum_array
   import mcp_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int CYCLES   = 3
) (
   input  logic                      clk1,
   input  logic                      rst,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic                      in_clr,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [CHANNELS*WIDTH-1:0] out_data,
   output logic [CHANNELS-1:0]       out_carry,
   output logic                      mc_launch,
   output logic                      mc_capture
);

   localparam int            CW       = cnt_width(CYCLES);
   localparam logic [CW-1:0] CNT_LOAD = CW'(CYCLES - 1);

   mcp_state_t    state_reg, state_next;
   logic [CW-1:0] cnt_reg, cnt_next;
   logic          fb_sel_reg;
   logic          out_valid_reg;
   logic          mc_launch_reg;
   logic          mc_capture_reg;
   logic          launch_en;
   logic          capture_en;

   // State, counter and observation registers
   always_ff @(posedge clk1) begin
      if (rst) begin
         state_reg      <= IDLE;
         cnt_reg        <= '0;
         fb_sel_reg     <= 1'b0;
         out_valid_reg  <= 1'b0;
         mc_launch_reg  <= 1'b0;
         mc_capture_reg <= 1'b0;
      end else begin
         state_reg      <= state_next;
         cnt_reg        <= cnt_next;
         if (launch_en) begin
            fb_sel_reg <= in_clr;
         end
         out_valid_reg  <= (state_next == HOLD);
         mc_launch_reg  <= launch_en;
         mc_capture_reg <= capture_en;
      end
   end

   // Next-state and counter
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               state_next = BUSY;
               cnt_next   = CNT_LOAD;
            end
         end
         BUSY: begin
            if (cnt_reg == '0) begin
               state_next = HOLD;
            end else begin
               cnt_next = cnt_reg - CW'(1);
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Outputs / enables decoded from state
   always_comb begin
      in_ready   = (state_reg == IDLE);
      launch_en  = (state_reg == IDLE) && in_valid;
      capture_en = (state_reg == BUSY) && (cnt_reg == '0);
   end

   assign out_valid  = out_valid_reg;
   assign mc_launch  = mc_launch_reg;
   assign mc_capture = mc_capture_reg;

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
      mcp_lane #(
         .WIDTH(WIDTH)
      ) u_lane (
         .clk1       (clk1),
         .rst        (rst),
         .launch_en  (launch_en),
         .capture_en (capture_en),
         .fb_clr     (fb_sel_reg),
         .launch_data(in_data[gi*WIDTH +: WIDTH]),
         .sum_data   (out_data[gi*WIDTH +: WIDTH]),
         .sum_carry  (out_carry[gi])
      );
   end

endmodule

// File: tb/tb_mcp_accum_array.sv
module tb_mcp_accum_array;

   localparam int CYCLES = 3;

   logic        clk1;
   logic        rst;

   // Main DUT: WIDTH=8, CHANNELS=4, CYCLES=3
   logic        in_valid, in_ready, in_clr, out_valid, out_ready;
   logic        mc_launch, mc_capture;
   logic [31:0] in_data, out_data;
   logic [3:0]  out_carry;

   // Second DUT: WIDTH=8, CHANNELS=2, CYCLES=1
   logic        in_valid1, in_ready1, in_clr1, out_valid1, out_ready1;
   logic        mc_launch1, mc_capture1;
   logic [15:0] in_data1, out_data1;
   logic [1:0]  out_carry1;

   mcp_accum_array #(.WIDTH(8), .CHANNELS(4), .CYCLES(CYCLES)) u_dut (
      .clk1(clk1), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_clr(in_clr),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_carry(out_carry), .mc_launch(mc_launch), .mc_capture(mc_capture)
   );

   mcp_accum_array #(.WIDTH(8), .CHANNELS(2), .CYCLES(1)) u_dut1 (
      .clk1(clk1), .rst(rst),
      .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .in_clr(in_clr1),
      .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
      .out_carry(out_carry1), .mc_launch(mc_launch1), .mc_capture(mc_capture1)
   );

   initial begin
      clk1 = 1'b0;
      forever #5 clk1 = ~clk1;
   end

   typedef struct {
      logic [31:0] data;
      logic        clr;
      logic [31:0] exp_data;
      logic [3:0]  exp_carry;
      int          hold;
   } vec_t;

   typedef struct packed {
      logic [31:0] d;
      logic [3:0]  c;
   } exp_t;

   typedef struct packed {
      logic [15:0] d;
      logic [1:0]  c;
   } exp1_t;

   vec_t  vecs[8];
   exp_t  sb_q[$];
   exp1_t sb1_q[$];
   int    n_cmp = 0;
   int    n_err = 0;

   task automatic tick();
      @(posedge clk1);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_op(input int idx, input logic [31:0] d, input logic clr,
                        input logic [31:0] ed, input logic [3:0] ec, input int hold);
      int   n;
      exp_t e;
      n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      chk("in_ready_before_op", 64'(in_ready), 64'd1);
      in_data  = d;
      in_clr   = clr;
      in_valid = 1'b1;
      tick();                                   // accept (launch) edge
      in_valid = 1'b0;
      in_clr   = 1'b0;
      sb_q.push_back('{d: ed, c: ec});
      chk("mc_launch_pulse", 64'(mc_launch), 64'd1);
      n = 0;
      while (!out_valid && n < 20) begin
         chk("in_ready_busy", 64'(in_ready), 64'd0);
         tick();
         n++;
      end
      chk("capture_latency", 64'(n), 64'(CYCLES));
      chk("mc_capture_pulse", 64'(mc_capture), 64'd1);
      // Backpressure: result must hold, new operands must be ignored
      for (int h = 0; h < hold; h++) begin
         in_valid  = 1'b1;
         in_data   = $urandom;
         out_ready = 1'b0;
         tick();
         chk("hold_out_valid", 64'(out_valid), 64'd1);
         chk("hold_in_ready", 64'(in_ready), 64'd0);
         chk("hold_out_data", 64'(out_data), 64'(sb_q[0].d));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      e = sb_q.pop_front();
      chk("out_data", 64'(out_data), 64'(e.d));
      chk("out_carry", 64'(out_carry), 64'(e.c));
      $display("op %0d: in=%h clr=%b -> out=%h carry=%b (expect %h/%b)",
               idx, d, clr, out_data, out_carry, e.d, e.c);
      tick();                                   // handshake edge
      out_ready = 1'b0;
      chk("out_valid_drop", 64'(out_valid), 64'd0);
      chk("in_ready_after", 64'(in_ready), 64'd1);
      chk("out_data_retained", 64'(out_data), 64'(e.d));
   endtask

   // Reset while BUSY (in_valid held high through the reset edge)
   task automatic mid_reset_seq();
      chk("mid_in_ready", 64'(in_ready), 64'd1);
      in_data  = 32'h55555555;
      in_clr   = 1'b0;
      in_valid = 1'b1;
      tick();                                   // launch edge T
      rst = 1'b1;
      tick();                                   // reset edge T+1
      rst      = 1'b0;
      in_valid = 1'b0;
      chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
      for (int k = 0; k < 4; k++) begin
         chk("mid_rst_no_valid", 64'(out_valid), 64'd0);
         chk("mid_rst_no_capture", 64'(mc_capture), 64'd0);
         tick();
      end
      chk("mid_rst_out_data", 64'(out_data), 64'd0);
      chk("mid_rst_out_carry", 64'(out_carry), 64'd0);
      $display("mid-BUSY reset applied");
      // Feedback was cleared: in_clr=0 must return the raw operand
      do_op(100, 32'h01020304, 1'b0, 32'h01020304, 4'b0000, 0);
   endtask

   // CYCLES=1 instance: out_ready tied high, in_valid held high
   task automatic cycles1_seq();
      logic [7:0]  fb1 [2];
      logic [8:0]  s;
      logic [15:0] ed;
      logic [1:0]  ec;
      int          last_acc;
      int          n_acc;
      exp1_t       e;
      fb1[0]    = 8'h00;
      fb1[1]    = 8'h00;
      last_acc  = -1;
      n_acc     = 0;
      in_valid1 = 1'b1;
      for (int k = 0; k < 40; k++) begin
         in_data1 = 16'($urandom);
         if (out_valid1) begin
            chk("c1_latency", 64'(k), 64'(last_acc + 2));
            chk("c1_mc_capture", 64'(mc_capture1), 64'd1);
            if (sb1_q.size() > 0) begin
               e = sb1_q.pop_front();
               chk("c1_out_data", 64'(out_data1), 64'(e.d));
               chk("c1_out_carry", 64'(out_carry1), 64'(e.c));
               $display("c1 result: out=%h carry=%b (expect %h/%b)", out_data1, out_carry1, e.d, e.c);
            end else begin
               chk("c1_unexpected_result", 64'(out_valid1), 64'd0);
            end
         end
         if (in_ready1) begin
            if (last_acc >= 0) begin
               chk("c1_accept_gap", 64'(k - last_acc), 64'd3);
            end
            for (int c = 0; c < 2; c++) begin
               s = {1'b0, fb1[c]} + {1'b0, in_data1[c*8 +: 8]};
               fb1[c]       = s[7:0];
               ed[c*8 +: 8] = s[7:0];
               ec[c]        = s[8];
            end
            sb1_q.push_back('{d: ed, c: ec});
            last_acc = k;
            n_acc++;
         end
         tick();
      end
      in_valid1 = 1'b0;
      chk("c1_accept_count", 64'(n_acc), 64'd14);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{data: 32'h04030201, clr: 1'b1, exp_data: 32'h04030201, exp_carry: 4'b0000, hold: 0};
      vecs[1] = '{data: 32'h010101EF, clr: 1'b0, exp_data: 32'h050403F0, exp_carry: 4'b0000, hold: 5};
      vecs[2] = '{data: 32'hFF008020, clr: 1'b0, exp_data: 32'h04048310, exp_carry: 4'b1001, hold: 1};
      vecs[3] = '{data: 32'h01010101, clr: 1'b0, exp_data: 32'h05058411, exp_carry: 4'b0000, hold: 1};
      vecs[4] = '{data: 32'h10203040, clr: 1'b1, exp_data: 32'h10203040, exp_carry: 4'b0000, hold: 0};
      vecs[5] = '{data: 32'hFFFFFFFF, clr: 1'b0, exp_data: 32'h0F1F2F3F, exp_carry: 4'b1111, hold: 2};
      vecs[6] = '{data: 32'h80808080, clr: 1'b1, exp_data: 32'h80808080, exp_carry: 4'b0000, hold: 0};
      vecs[7] = '{data: 32'h80808080, clr: 1'b0, exp_data: 32'h00000000, exp_carry: 4'b1111, hold: 1};

      rst        = 1'b1;
      in_valid   = 1'b0;
      in_data    = '0;
      in_clr     = 1'b0;
      out_ready  = 1'b0;
      in_valid1  = 1'b0;
      in_data1   = '0;
      in_clr1    = 1'b0;
      out_ready1 = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_data", 64'(out_data), 64'd0);
      chk("rst_out_carry", 64'(out_carry), 64'd0);
      chk("rst_mc_launch", 64'(mc_launch), 64'd0);
      chk("rst_mc_capture", 64'(mc_capture), 64'd0);
      chk("rst_c1_in_ready", 64'(in_ready1), 64'd1);
      tick();
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);

      for (int i = 0; i < 8; i++) begin
         if (i == 4) begin
            mid_reset_seq();
         end
         do_op(i, vecs[i].data, vecs[i].clr, vecs[i].exp_data, vecs[i].exp_carry, vecs[i].hold);
      end

      cycles1_seq();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mcp_accum_array.md
Name: mcp_accum_array

Overview:
- Parametrised successor to the single-bit multicycle launch/capture pair: CHANNELS independent WIDTH-bit accumulator lanes.
- In each lane, the combinational adder between the launch and capture registers is a deliberate multicycle path of exactly CYCLES clock periods.
- A counter FSM generates the launch and capture enables, so `set_multicycle_path -setup CYCLES` (from launch regs, through the adder, to capture regs) is functionally correct.
- Sits between a valid/ready producer and a valid/ready consumer; used as an SDC timing benchmark.

Parameters:
- WIDTH, 8, data width per lane (>=1)
- CHANNELS, 4, number of independent lanes (>=1)
- CYCLES, 3, multicycle factor: capture edge is CYCLES edges after launch edge (>=1)

Ports:
- clk1  input  1  single clock; all state on posedge
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  producer has an operand vector
- in_ready  output  1  block accepts operand (IDLE only)
- in_data  input  CHANNELS*WIDTH  operands, lane c at bits [c*WIDTH +: WIDTH]
- in_clr  input  1  sampled with the accepted operand; that operation uses feedback 0
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- out_data  output  CHANNELS*WIDTH  captured sums, same lane packing
- out_carry  output  CHANNELS  carry-out of each lane's add
- mc_launch  output  1  registered copy of launch enable (observation/SDC -through point)
- mc_capture  output  1  registered copy of capture enable

Behaviour:
- Reset (rst=1 at edge) clears all state, including mid-operation and with in_valid high:
  - state=IDLE, counter=0
  - launch regs, feedback, out_data, out_carry = 0
  - out_valid=0, mc_launch=0, mc_capture=0
  - in_ready=1 from the first cycle after reset deasserts.
- FSM states: IDLE, BUSY, HOLD. in_ready = (state==IDLE), combinational from state.
- IDLE: on the edge where in_valid&&in_ready:
  - launch_c <= in_data lane c
  - fb_sel <= in_clr
  - cnt <= CYCLES-1
  - state -> BUSY; mc_launch pulses 1 cycle.
- BUSY:
  - Each edge with cnt!=0: cnt decrements.
  - Edge with cnt==0 (capture): out_data lane c <= launch_c + (fb_sel ? 0 : fb_c), mod 2^WIDTH; out_carry[c] <= carry bit; fb_c <= same sum; state -> HOLD; mc_capture pulses 1 cycle.
- Capture edge is exactly CYCLES edges after the launch edge. CYCLES=1 degenerates to a single-cycle path (BUSY lasts one cycle).
- Launch regs and fb are stable from launch edge to capture edge; the adder inputs never change inside the window (this is what makes the multicycle constraint safe).
- HOLD:
  - out_valid=1; out_data and out_carry held stable.
  - On out_ready=1: state -> IDLE and out_valid drops next cycle. out_data is retained until the next capture.
- Throughput: max one operation per CYCLES+2 cycles (accept, CYCLES, handshake).
- in_valid is ignored outside IDLE. out_ready is ignored outside HOLD.
- Feedback persists across operations (accumulate) until an operation with in_clr=1, or reset.
- Counter width: max(1, clog2(CYCLES)).
- No X-propagation: all registers are reset.

Decomposition:
- Shared package mcp_pkg:
  - FSM state encoding constants: IDLE=2'd0, BUSY=2'd1, HOLD=2'd2.
  - Counter-width function.
- Sub-module mcp_lane (one per channel, generate loop) contains:
  - WIDTH launch register
  - feedback register
  - adder
  - capture register plus carry
- mcp_lane takes launch_en, capture_en and fb_clr from the top-level FSM. The top level holds only the FSM, counter and handshake.

Test Plan:
- Reset/defaults: assert rst 2 cycles -> out_valid=0, in_ready=1, out_data=0, out_carry=0; mc_launch=mc_capture=0.
- Latency, CYCLES=3, CHANNELS=4, WIDTH=8: accept in_data={8'd4,8'd3,8'd2,8'd1} with in_clr=1 at edge T -> mc_capture at edge T+3; out_valid high from T+3; out_data={4,3,2,1}; in_ready=0 during T+1..T+3.
- Accumulate and wrap: previous result 8'hF0; accept 8'h20 with in_clr=0 -> lane sum 8'h10, out_carry=1. Next op 8'h01 -> 8'h11, carry 0.
- Backpressure: hold out_ready=0 for 5 cycles -> out_valid and out_data stable, in_ready=0 and in_valid ignored. out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-BUSY: rst at cycle T+1 after launch -> no capture pulse; out_valid stays 0; fb=0, so the next op with in_clr=0 returns raw operand.
- CYCLES=1 build: capture on the edge immediately after launch; back-to-back ops with out_ready tied 1 -> in_ready high every 3rd cycle.
